// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cal_pkg
// Brief    : Shared constants for the calibration result accumulator.
// Revision : 1.0
// ============================================================================
package cal_pkg;

   localparam int CAL_DATA_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CAL_DATA_W-1:0] MAX_INIT = 8'h80;
   localparam logic [CAL_DATA_W-1:0] MIN_INIT = 8'h7F;

endpackage
`default_nettype wire

// File: rtl/cal_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : cal_sat_add
// Brief    : Combinational signed adder with overflow detect; clamps when
//            CAL_RESULT_ACCUM_SAT_EN is defined, otherwise wraps.
// Revision : 1.0
// ============================================================================
module cal_sat_add #(
   parameter int ACC_W = 12
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   logic [ACC_W:0] w_wide;

   assign w_wide = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
   // The extra bit disagrees with the sign bit exactly when the result left range
   assign ovf    = w_wide[ACC_W] ^ w_wide[ACC_W-1];

`ifdef CAL_RESULT_ACCUM_SAT_EN
   always_comb begin
      sum = w_wide[ACC_W-1:0];
      if (ovf) begin
         sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sum = w_wide[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/cal_result_accum.sv
`default_nettype none
// ============================================================================
// Module   : cal_result_accum
// Brief    : Frame accumulator (sum/max/min/count/overflow) with valid/ready
//            result hold. Optional macro: CAL_RESULT_ACCUM_SAT_EN (saturate).
// Revision : 1.0
// ============================================================================
module cal_result_accum
   import cal_pkg::*;
#(
   parameter int NUM_SAMPLES = 32,
   parameter int ACC_W       = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_start,
   input  logic                  in_cal_valid,
   input  logic [CAL_DATA_W-1:0] in_cal_data,
   input  logic                  in_out_ready,
   output logic                  out_busy,
   output logic                  out_valid,
   output logic [ACC_W-1:0]      out_sum,
   output logic [CAL_DATA_W-1:0] out_max,
   output logic [CAL_DATA_W-1:0] out_min,
   output logic [7:0]            out_count,
   output logic                  out_ovf
);

   localparam logic [7:0] c_last_count = 8'(NUM_SAMPLES - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_state_next;
   logic [ACC_W-1:0]      r_sum;
   logic [CAL_DATA_W-1:0] r_max;
   logic [CAL_DATA_W-1:0] r_min;
   logic [7:0]            r_count;
   logic                  r_ovf;

   logic [ACC_W-1:0]      w_sample_ext;
   logic [ACC_W-1:0]      w_sum_next;
   logic                  w_add_ovf;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_clear;

   assign w_sample_ext = {{(ACC_W-CAL_DATA_W){in_cal_data[CAL_DATA_W-1]}}, in_cal_data};
   assign w_accept     = (r_state == ST_ACCUM) && in_cal_valid;
   assign w_last       = w_accept && (r_count == c_last_count);
   assign w_clear      = (r_state == ST_IDLE) && in_start;

   cal_sat_add #(
      .ACC_W (ACC_W)
   ) u_sat_add (
      .acc    (r_sum),
      .addend (w_sample_ext),
      .sum    (w_sum_next),
      .ovf    (w_add_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (in_start)     w_state_next = ST_ACCUM;
         ST_ACCUM: if (w_last)       w_state_next = ST_DONE;
         ST_DONE:  if (in_out_ready) w_state_next = ST_IDLE;
         default:                    w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      out_busy  = (r_state == ST_ACCUM);
      out_valid = (r_state == ST_DONE);
   end

   // Result registers only move on a start in IDLE or an accepted sample
   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_sum   <= '0;
         r_max   <= MAX_INIT;
         r_min   <= MIN_INIT;
         r_count <= 8'd0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_sum   <= w_sum_next;
         r_ovf   <= r_ovf | w_add_ovf;
         r_count <= r_count + 8'd1;
         if ($signed(in_cal_data) > $signed(r_max)) begin
            r_max <= in_cal_data;
         end
         if ($signed(in_cal_data) < $signed(r_min)) begin
            r_min <= in_cal_data;
         end
      end
   end

   assign out_sum   = r_sum;
   assign out_max   = r_max;
   assign out_min   = r_min;
   assign out_count = r_count;
   assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cal_result_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_cal_result_accum
// Brief    : Randomised scoreboard bench for cal_result_accum.
// Revision : 1.0
// ============================================================================
module tb_cal_result_accum;

   localparam int N    = 4;
   localparam int AW   = 9;
   localparam int MAXV = (2 ** (AW - 1)) - 1;
   localparam int MINV = -(2 ** (AW - 1));
`ifdef CAL_RESULT_ACCUM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_start;
   logic          in_cal_valid;
   logic [7:0]    in_cal_data;
   logic          in_out_ready;
   logic          out_busy;
   logic          out_valid;
   logic [AW-1:0] out_sum;
   logic [7:0]    out_max;
   logic [7:0]    out_min;
   logic [7:0]    out_count;
   logic          out_ovf;

   cal_result_accum #(
      .NUM_SAMPLES (N),
      .ACC_W       (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_start     (in_start),
      .in_cal_valid (in_cal_valid),
      .in_cal_data  (in_cal_data),
      .in_out_ready (in_out_ready),
      .out_busy     (out_busy),
      .out_valid    (out_valid),
      .out_sum      (out_sum),
      .out_max      (out_max),
      .out_min      (out_min),
      .out_count    (out_count),
      .out_ovf      (out_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] sum;
      logic [7:0]    mx;
      logic [7:0]    mn;
      logic [7:0]    cnt;
      logic          ovf;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   exp_t held;
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: true integer sum, clamped or wrapped whenever it leaves range
   function automatic exp_t model(input int s[$]);
      exp_t e;
      int   acc = 0;
      int   mx  = -128;
      int   mn  = 127;
      bit   ov  = 1'b0;
      for (int i = 0; i < s.size(); i++) begin
         acc += s[i];
         if (acc > MAXV || acc < MINV) begin
            ov = 1'b1;
            if (SAT) acc = (acc > MAXV) ? MAXV : MINV;
            else     acc = (acc > MAXV) ? acc - (2 ** AW) : acc + (2 ** AW);
         end
         if (s[i] > mx) mx = s[i];
         if (s[i] < mn) mn = s[i];
      end
      e.sum = AW'(acc);
      e.mx  = 8'(mx);
      e.mn  = 8'(mn);
      e.cnt = 8'(s.size());
      e.ovf = ov;
      e.cyc = 0;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int s[$], input bit start_valid, input int hold);
      exp_t e;
      in_start     = 1'b1;
      in_cal_valid = start_valid;
      in_cal_data  = 8'($urandom);
      tick();
      for (int i = 0; i < s.size(); i++) begin
         repeat ($urandom % 3) begin
            in_start     = ($urandom % 4) == 0;
            in_cal_valid = 1'b0;
            in_cal_data  = 8'($urandom);
            tick();
         end
         in_start     = ($urandom % 4) == 0;
         in_cal_valid = 1'b1;
         in_cal_data  = 8'(s[i]);
         if (i == s.size() - 1) begin
            e     = model(s);
            e.cyc = cyc;
            sb.push_back(e);
         end
         tick();
      end
      // Result held under backpressure while junk starts/samples arrive
      repeat (hold) begin
         in_out_ready = 1'b0;
         in_start     = $urandom % 2;
         in_cal_valid = $urandom % 2;
         in_cal_data  = 8'($urandom);
         tick();
      end
      in_start     = 1'b0;
      in_cal_valid = 1'b0;
      in_out_ready = 1'b1;
      tick();
      in_out_ready = 1'b0;
   endtask

   bit prev_valid = 1'b0;
   bit hs_prev    = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         hs_prev    = 1'b0;
      end else begin
         if (hs_prev) begin
            check("post_hs_valid", 32'(out_valid), 32'd0);
            check("post_hs_busy", 32'(out_busy), 32'd0);
            check("post_hs_sum_kept", 32'(out_sum), 32'(held.sum));
         end
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               held = sb.pop_front();
               check("latency", 32'(cyc), 32'(held.cyc + 1));
               check("sum", 32'(out_sum), 32'(held.sum));
               check("max", 32'(out_max), 32'(held.mx));
               check("min", 32'(out_min), 32'(held.mn));
               check("count", 32'(out_count), 32'(held.cnt));
               check("ovf", 32'(out_ovf), 32'(held.ovf));
               check("busy_in_done", 32'(out_busy), 32'd0);
            end
         end else if (out_valid) begin
            check("hold_sum", 32'(out_sum), 32'(held.sum));
            check("hold_max", 32'(out_max), 32'(held.mx));
            check("hold_min", 32'(out_min), 32'(held.mn));
            check("hold_count", 32'(out_count), 32'(held.cnt));
            check("hold_ovf", 32'(out_ovf), 32'(held.ovf));
         end
         prev_valid = out_valid;
         hs_prev    = out_valid && in_out_ready;
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 32'(out_busy), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_sum"}, 32'(out_sum), 32'd0);
      check({tag, "_max"}, 32'(out_max), 32'h80);
      check({tag, "_min"}, 32'(out_min), 32'h7F);
      check({tag, "_count"}, 32'(out_count), 32'd0);
      check({tag, "_ovf"}, 32'(out_ovf), 32'd0);
   endtask

   initial begin
      int q[$];
      rst          = 1'b1;
      in_start     = 1'b0;
      in_cal_valid = 1'b0;
      in_cal_data  = 8'h00;
      in_out_ready = 1'b0;
      repeat (2) begin
         in_start     = $urandom % 2;
         in_cal_valid = $urandom % 2;
         in_cal_data  = 8'($urandom);
         in_out_ready = $urandom % 2;
         tick();
      end
      check_reset_state("reset");
      rst          = 1'b0;
      in_start     = 1'b0;
      in_cal_valid = 1'b0;
      in_out_ready = 1'b0;
      tick();

      q = '{5, -2, 12, 0};
      run_frame(q, 1'b0, 5);
      q = '{127, 127, 127, 127};
      run_frame(q, 1'b0, 1);
      q = '{-128, -128, -128, -1};
      run_frame(q, 1'b0, 0);
      q = '{1, 2, 3, 4};
      run_frame(q, 1'b1, 2);

      // Abort a frame after three samples
      in_start     = 1'b1;
      in_cal_valid = 1'b0;
      tick();
      in_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_cal_valid = 1'b1;
         in_cal_data  = 8'h7F;
         tick();
      end
      check("midframe_busy", 32'(out_busy), 32'd1);
      check("midframe_count", 32'(out_count), 32'd3);
      rst          = 1'b1;
      in_cal_valid = 1'b1;
      tick();
      rst          = 1'b0;
      in_cal_valid = 1'b0;
      check_reset_state("midreset");
      tick();
      q = '{1, 1, 1, 1};
      run_frame(q, 1'b0, 1);

      for (int f = 0; f < 24; f++) begin
         q.delete();
         for (int i = 0; i < N; i++) begin
            if (f % 3 == 0) q.push_back(int'($urandom_range(0, 20)) - 10);
            else            q.push_back(int'($urandom_range(0, 255)) - 128);
         end
         run_frame(q, $urandom % 2, $urandom % 4);
      end

      repeat (3) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
